// File: rtl/mole_controller.sv
// Whack-a-mole mole controller: lights one LED per mole for a difficulty-dependent
// time and judges debounced whack pulses, returning one-cycle hit/miss/timeout pulses.
module mole_controller #(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned GAP_MS    = 200,
  parameter int unsigned UP_MS_0   = 1000,
  parameter int unsigned UP_MS_1   = 700,
  parameter int unsigned UP_MS_2   = 400,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] difficulty_level,
  input  logic [3:0] btn_hit,
  output logic [3:0] mole_leds,
  output logic [1:0] mole_index,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       timeout_pulse
);

  localparam int unsigned PW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned M01    = (UP_MS_0 > UP_MS_1) ? UP_MS_0 : UP_MS_1;
  localparam int unsigned M012   = (M01 > UP_MS_2) ? M01 : UP_MS_2;
  localparam int unsigned MS_MAX = (M012 > GAP_MS) ? M012 : GAP_MS;
  localparam int unsigned MS_W   = $clog2(MS_MAX + 1);

  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [MS_W-1:0] GAP_LAST  = MS_W'(GAP_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_UP   = 2'd2
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   presc_q;
  logic [MS_W-1:0] ms_cnt_q;
  logic [15:0]     lfsr_q;
  logic [1:0]      diff_q;
  logic [3:0]      leds_q;
  logic [1:0]      idx_q;
  logic            hit_q;
  logic            miss_q;
  logic            to_q;

  logic [15:0]     lfsr_d;
  logic [PW-1:0]   presc_d;
  logic            ms_tick;
  logic [1:0]      cand;
  logic [1:0]      idx_d;
  logic [MS_W-1:0] up_last;
  logic            gap_done;
  logic            up_done;
  logic            btn_match;
  logic            btn_any;

  // Galois right-shift LFSR, free running so the mole position depends on player timing.
  assign lfsr_d  = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ 16'hB400) : {1'b0, lfsr_q[15:1]};
  assign ms_tick = (state_q != S_IDLE) && (presc_q == TICK_LAST);
  assign presc_d = ms_tick ? '0 : presc_q + PW'(1);

  assign cand  = lfsr_q[1:0];
  assign idx_d = (cand == idx_q) ? cand + 2'd1 : cand;

  always_comb begin
    up_last = MS_W'(UP_MS_2 - 1);
    case (diff_q)
      2'd0:    up_last = MS_W'(UP_MS_0 - 1);
      2'd1:    up_last = MS_W'(UP_MS_1 - 1);
      default: up_last = MS_W'(UP_MS_2 - 1);
    endcase
  end

  assign gap_done  = ms_tick && (ms_cnt_q == GAP_LAST);
  assign up_done   = ms_tick && (ms_cnt_q == up_last);
  assign btn_match = (btn_hit == leds_q);
  assign btn_any   = (btn_hit != 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      ms_cnt_q <= '0;
      lfsr_q   <= LFSR_SEED;
      diff_q   <= 2'd0;
      leds_q   <= 4'd0;
      idx_q    <= 2'd0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      to_q   <= 1'b0;
      if (!enable) begin
        // Abort silently: no verdict for a mole cut short by the FSM.
        state_q  <= S_IDLE;
        presc_q  <= '0;
        ms_cnt_q <= '0;
        leds_q   <= 4'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q  <= S_GAP;
            presc_q  <= '0;
            ms_cnt_q <= '0;
          end
          S_GAP: begin
            presc_q <= presc_d;
            if (gap_done) begin
              state_q  <= S_UP;
              ms_cnt_q <= '0;
              idx_q    <= idx_d;
              leds_q   <= 4'b0001 << idx_d;
              diff_q   <= difficulty_level;
            end else if (ms_tick) begin
              ms_cnt_q <= ms_cnt_q + MS_W'(1);
            end
          end
          S_UP: begin
            presc_q <= presc_d;
            if (btn_match) begin
              hit_q    <= 1'b1;
              leds_q   <= 4'd0;
              state_q  <= S_GAP;
              ms_cnt_q <= '0;
            end else begin
              // A wrong press does not stop the timer, so miss and timeout may coincide.
              miss_q <= btn_any;
              if (up_done) begin
                to_q     <= 1'b1;
                leds_q   <= 4'd0;
                state_q  <= S_GAP;
                ms_cnt_q <= '0;
              end else if (ms_tick) begin
                ms_cnt_q <= ms_cnt_q + MS_W'(1);
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            leds_q  <= 4'd0;
          end
        endcase
      end
    end
  end

  assign mole_leds     = leds_q;
  assign mole_index    = idx_q;
  assign hit_pulse     = hit_q;
  assign miss_pulse    = miss_q;
  assign timeout_pulse = to_q;

endmodule

// File: tb/tb_mole_controller.sv
// Directed plus randomized bench for mole_controller with a cycle-stepped
// behavioural reference model expressed in milliseconds and mole phases.
module tb_mole_controller;
  localparam int          TD   = 4;
  localparam int          GAP  = 3;
  localparam int          U0   = 5;
  localparam int          U1   = 4;
  localparam int          U2   = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] difficulty_level = 2'd0;
  logic [3:0] btn_hit = 4'd0;
  logic [3:0] mole_leds;
  logic [1:0] mole_index;
  logic       hit_pulse, miss_pulse, timeout_pulse;

  int errors = 0;
  int checks = 0;

  mole_controller #(
    .TICK_DIV(TD), .GAP_MS(GAP), .UP_MS_0(U0), .UP_MS_1(U1), .UP_MS_2(U2), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .difficulty_level(difficulty_level),
    .btn_hit(btn_hit), .mole_leds(mole_leds), .mole_index(mole_index),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  // reference model: running flag, phase (gap/up), cycles since start, ms in phase
  bit          m_run = 1'b0;
  bit          m_up  = 1'b0;
  int          m_cyc = 0;
  int          m_ms  = 0;
  int          m_dur = U0;
  logic [15:0] m_lfsr = SEED;
  logic [3:0]  e_leds = 4'd0;
  logic [1:0]  e_idx  = 2'd0;
  logic        e_hit = 1'b0, e_miss = 1'b0, e_to = 1'b0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int up_ms(input logic [1:0] d);
    if (d == 2'd0) return U0;
    if (d == 2'd1) return U1;
    return U2;
  endfunction

  function automatic logic [3:0] pick_wrong(input logic [1:0] k);
    logic [3:0] w;
    w = 4'($urandom_range(1, 15));
    while (w == (4'b0001 << k)) w = 4'($urandom_range(1, 15));
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [15:0] cur;
    logic [1:0]  c;
    bit          tick;
    cur = m_lfsr;
    e_hit = 1'b0; e_miss = 1'b0; e_to = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_up = 1'b0; m_cyc = 0; m_ms = 0; m_dur = U0;
      m_lfsr = SEED; e_leds = 4'd0; e_idx = 2'd0;
      return;
    end
    m_lfsr = lfsr_next(cur);
    if (!enable) begin
      m_run = 1'b0; m_up = 1'b0; e_leds = 4'd0;
      return;
    end
    if (!m_run) begin
      m_run = 1'b1; m_up = 1'b0; m_cyc = 0; m_ms = 0;
      return;
    end
    tick  = ((m_cyc % TD) == TD - 1);
    m_cyc = m_cyc + 1;
    if (!m_up) begin
      if (tick) begin
        if (m_ms + 1 == GAP) begin
          c = cur[1:0];
          e_idx  = (c == e_idx) ? c + 2'd1 : c;
          e_leds = 4'b0001 << e_idx;
          m_dur  = up_ms(difficulty_level);
          m_up = 1'b1; m_ms = 0;
        end else m_ms = m_ms + 1;
      end
    end else if (btn_hit == e_leds) begin
      e_hit = 1'b1; e_leds = 4'd0; m_up = 1'b0; m_ms = 0;
    end else begin
      e_miss = (btn_hit != 4'd0);
      if (tick) begin
        if (m_ms + 1 == m_dur) begin
          e_to = 1'b1; e_leds = 4'd0; m_up = 1'b0; m_ms = 0;
        end else m_ms = m_ms + 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic en, input logic [1:0] d, input logic [3:0] b);
    @(negedge clk);
    rst = r; enable = en; difficulty_level = d; btn_hit = b;
    @(posedge clk);
    model_edge();
    #1;
    check("cycle", 32'({mole_leds, mole_index, hit_pulse, miss_pulse, timeout_pulse}),
          32'({e_leds, e_idx, e_hit, e_miss, e_to}));
  endtask

  // steps until a mole is lit; n = number of steps taken
  task automatic wait_rise(input logic [1:0] d, output int n);
    n = 0;
    while (mole_leds == 4'd0 && n < 200) begin
      step(1'b0, 1'b1, d, 4'd0);
      n++;
    end
    check("rise_seen", 32'(mole_leds != 4'd0), 32'd1);
  endtask

  // counts lit samples including the rising one; d2 applied from the 2nd step on
  task automatic up_len(input logic [1:0] d2, output int n);
    n = 1;
    for (int j = 1; j <= 200 && mole_leds != 4'd0; j++) begin
      step(1'b0, 1'b1, d2, 4'd0);
      if (mole_leds != 4'd0) n++;
    end
  endtask

  initial begin
    int          n;
    int          t;
    int          misses;
    logic [1:0]  k;
    logic [1:0]  prev_e;
    logic [1:0]  first_idx;
    logic [15:0] v;
    logic [3:0]  wrong;

    // first mole reads the LFSR 12 edges after the first enabled edge; index 0 is a repeat
    v = SEED;
    for (int i = 0; i < 12; i++) v = lfsr_next(v);
    first_idx = (v[1:0] == 2'd0) ? 2'd1 : v[1:0];

    step(1'b1, 1'b0, 2'd0, 4'd0);
    step(1'b1, 1'b0, 2'd0, 4'd0);
    check("rst_outs", 32'({mole_leds, mole_index, hit_pulse, miss_pulse, timeout_pulse}), 32'd0);

    // enable: 12 dark cycles after the enabling edge, then the first mole
    wait_rise(2'd0, n);
    check("gap0_len", 32'(n), 32'd13);
    check("first_idx", 32'(mole_index), 32'(first_idx));

    up_len(2'd0, n);
    check("up_d0_len", 32'(n), 32'd20);
    check("timeout_pulse", 32'(timeout_pulse), 32'd1);
    prev_e = e_idx;
    wait_rise(2'd0, n);
    check("gap_len", 32'(n), 32'd12);
    check("no_repeat", 32'(mole_index == prev_e), 32'd0);

    // correct whack
    k = mole_index;
    step(1'b0, 1'b1, 2'd0, 4'd0);
    step(1'b0, 1'b1, 2'd0, 4'd0);
    step(1'b0, 1'b1, 2'd0, 4'b0001 << k);
    check("hit_pulse", 32'(hit_pulse), 32'd1);
    check("hit_dark", 32'(mole_leds), 32'd0);
    t = 0;
    repeat (8) begin
      step(1'b0, 1'b1, 2'd0, 4'd0);
      t += int'(timeout_pulse);
    end
    check("no_to_after_hit", 32'(t), 32'd0);

    // two wrong presses: mole stays, expires on schedule
    wait_rise(2'd0, n);
    k = mole_index;
    wrong = pick_wrong(k);
    n = 1; misses = 0;
    for (int j = 1; j <= 40 && mole_leds != 4'd0; j++) begin
      step(1'b0, 1'b1, 2'd0, (j == 2) ? wrong : ((j == 5) ? 4'hF : 4'h0));
      misses += int'(miss_pulse);
      if (mole_leds != 4'd0) n++;
    end
    check("miss_count", 32'(misses), 32'd2);
    check("miss_up_len", 32'(n), 32'd20);

    // correct press on the expiry edge: hit wins
    wait_rise(2'd0, n);
    k = mole_index;
    for (int j = 1; j <= 20; j++) step(1'b0, 1'b1, 2'd0, (j == 20) ? (4'b0001 << k) : 4'h0);
    check("exp_hit", 32'({hit_pulse, timeout_pulse, mole_leds}), 32'({1'b1, 1'b0, 4'd0}));

    // wrong press on the expiry edge: miss and timeout together
    wait_rise(2'd0, n);
    k = mole_index;
    wrong = pick_wrong(k);
    for (int j = 1; j <= 20; j++) step(1'b0, 1'b1, 2'd0, (j == 20) ? wrong : 4'h0);
    check("exp_miss_to", 32'({hit_pulse, miss_pulse, timeout_pulse, mole_leds}),
          32'({1'b0, 1'b1, 1'b1, 4'd0}));

    // drop enable mid-UP with a correct press in the same cycle
    wait_rise(2'd0, n);
    k = mole_index;
    prev_e = e_idx;
    step(1'b0, 1'b1, 2'd0, 4'd0);
    step(1'b0, 1'b0, 2'd0, 4'b0001 << k);
    check("dis_quiet", 32'({mole_leds, hit_pulse, miss_pulse, timeout_pulse}), 32'd0);
    check("dis_idx_kept", 32'(mole_index), 32'(prev_e));
    step(1'b0, 1'b0, 2'd2, 4'd0);
    wait_rise(2'd2, n);
    check("reen_gap_len", 32'(n), 32'd13);
    up_len(2'd0, n);
    check("up_d2_len", 32'(n), 32'd8);
    check("d2_timeout", 32'(timeout_pulse), 32'd1);

    // randomized play
    for (int i = 0; i < 600; i++) begin
      logic [3:0] b;
      b = 4'd0;
      if ($urandom_range(0, 7) == 0)
        b = ($urandom_range(0, 1) == 0) ? (4'b0001 << mole_index) : 4'($urandom_range(0, 15));
      step(1'b0, ($urandom_range(0, 59) != 0), 2'($urandom_range(0, 3)), b);
    end

    // reset mid-UP reloads the seed: same timing reproduces the first mole
    wait_rise(2'd0, n);
    step(1'b0, 1'b1, 2'd0, 4'd0);
    step(1'b1, 1'b1, 2'd0, 4'b0001 << mole_index);
    check("rst_mid_up", 32'({mole_leds, mole_index, hit_pulse, miss_pulse, timeout_pulse}), 32'd0);
    step(1'b1, 1'b0, 2'd0, 4'd0);
    wait_rise(2'd0, n);
    check("rst_gap_len", 32'(n), 32'd13);
    check("rst_reseed_idx", 32'(mole_index), 32'(first_idx));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
